// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754-style add/subtract with round-to-nearest-even and status flags.
// One operation in flight; valid/ready on both sides; subnormals flush to zero.
module fp_addsub_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam int XW = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d;
  logic                  op_q, op_d;
  logic                  sign_q, sign_d, sub_q, sub_d;
  logic signed [XW-1:0]  exp_q, exp_d;
  logic [SW-1:0]         big_q, big_d, small_q, small_d, norm_q, norm_d;
  logic [SW:0]           sum_q, sum_d;
  logic                  zero_q, zero_d;
  logic                  spec_q, spec_d;
  logic [W-1:0]          spec_res_q, spec_res_d;
  logic [3:0]            spec_flags_q, spec_flags_d;
  logic                  out_valid_q, out_valid_d;
  logic [W-1:0]          result_q, result_d;
  logic [3:0]            flags_q, flags_d;

  function automatic logic [XW-1:0] lzc(input logic [SW-1:0] v);
    logic [XW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found && !v[i]) n = n + 1'b1;
      else found = 1'b1;
    end
    return n;
  endfunction

  // Right shift into guard/round/sticky; everything shifted past bit 0 collapses into sticky.
  function automatic logic [SW-1:0] align_shift(input logic [SW-1:0] sig,
                                                input logic [EXP_W-1:0] d);
    logic [2*SW-1:0] wide;
    int              sh;
    sh   = (int'(d) > SW) ? SW : int'(d);
    wide = {sig, {SW{1'b0}}} >> sh;
    return {wide[2*SW-1:SW+1], wide[SW] | (|wide[SW-1:0])};
  endfunction

  function automatic logic rne_up(input logic [SW-1:0] s);
    return s[2] & (s[1] | s[0] | s[3]);
  endfunction

  logic                 a_s, b_es, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, b_big;
  logic [EXP_W-1:0]     a_e, b_e, big_e, small_e;
  logic [MAN_W-1:0]     a_f, b_f, big_f, small_f, frac_r;
  logic [XW-1:0]        lz;
  logic [MAN_W+1:0]     mant_r;
  logic signed [XW-1:0] exp_r;

  assign a_s     = a_q[W-1];
  assign a_e     = a_q[W-2:MAN_W];
  assign a_f     = a_q[MAN_W-1:0];
  assign b_es    = b_q[W-1] ^ op_q;
  assign b_e     = b_q[W-2:MAN_W];
  assign b_f     = b_q[MAN_W-1:0];
  assign a_nan   = (a_e == EXP_ONES) && (a_f != '0);
  assign b_nan   = (b_e == EXP_ONES) && (b_f != '0);
  assign a_inf   = (a_e == EXP_ONES) && (a_f == '0);
  assign b_inf   = (b_e == EXP_ONES) && (b_f == '0);
  assign a_zero  = (a_e == '0);
  assign b_zero  = (b_e == '0);
  assign b_big   = {b_e, b_f} > {a_e, a_f};
  assign big_e   = b_big ? b_e : a_e;
  assign big_f   = b_big ? b_f : a_f;
  assign small_e = b_big ? a_e : b_e;
  assign small_f = b_big ? a_f : b_f;
  assign lz      = lzc(sum_q[SW-1:0]);
  assign mant_r  = {1'b0, norm_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, rne_up(norm_q)};
  assign exp_r   = mant_r[MAN_W+1] ? exp_q + XW'(1) : exp_q;
  assign frac_r  = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    sign_d       = sign_q;
    sub_d        = sub_q;
    exp_d        = exp_q;
    big_d        = big_q;
    small_d      = small_q;
    sum_d        = sum_q;
    norm_d       = norm_q;
    zero_d       = zero_q;
    spec_d       = spec_q;
    spec_res_d   = spec_res_q;
    spec_flags_d = spec_flags_q;
    out_valid_d  = out_valid_q;
    result_d     = result_q;
    flags_d      = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        spec_d       = 1'b1;
        spec_flags_d = 4'b0000;
        spec_res_d   = a_q;
        if (a_nan || b_nan)        spec_res_d = QNAN;
        else if (a_inf && b_inf) begin
          if (a_s != b_es) begin
            spec_res_d   = QNAN;
            spec_flags_d = 4'b1000;
          end
        end
        else if (a_inf)            spec_res_d = a_q;
        else if (b_inf)            spec_res_d = {b_es, b_e, b_f};
        else if (a_zero && b_zero) spec_res_d = {a_s & b_es, {(W-1){1'b0}}};
        else if (a_zero)           spec_res_d = {b_es, b_e, b_f};
        else if (b_zero)           spec_res_d = a_q;
        else                       spec_d     = 1'b0;
        sign_d  = b_big ? b_es : a_s;
        sub_d   = a_s ^ b_es;
        exp_d   = {2'b00, big_e};
        big_d   = {1'b1, big_f, 3'b000};
        small_d = align_shift({1'b1, small_f, 3'b000}, big_e - small_e);
        state_d = ADD;
      end
      ADD: begin
        sum_d   = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
        state_d = NORM;
      end
      NORM: begin
        zero_d = (sum_q == '0);
        if (sum_q[SW]) begin
          norm_d = {sum_q[SW:2], sum_q[1] | sum_q[0]};
          exp_d  = exp_q + XW'(1);
        end else begin
          norm_d = sum_q[SW-1:0] << lz;
          exp_d  = exp_q - lz;
        end
        state_d = ROUND;
      end
      ROUND: begin
        if (spec_q) begin
          result_d = spec_res_q;
          flags_d  = spec_flags_q;
        end else if (zero_q) begin
          result_d = '0;
          flags_d  = 4'b0000;
        end else if (exp_r >= $signed({2'b00, EXP_ONES})) begin
          result_d = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
          flags_d  = 4'b0101;
        end else if (exp_r <= 0) begin
          result_d = {sign_q, {(W-1){1'b0}}};
          flags_d  = 4'b0011;
        end else begin
          result_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
          flags_d  = {3'b000, |norm_q[2:0]};
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q          <= a_d;
    b_q          <= b_d;
    op_q         <= op_d;
    sign_q       <= sign_d;
    sub_q        <= sub_d;
    exp_q        <= exp_d;
    big_q        <= big_d;
    small_q      <= small_d;
    sum_q        <= sum_d;
    norm_q       <= norm_d;
    zero_q       <= zero_d;
    spec_q       <= spec_d;
    spec_res_q   <= spec_res_d;
    spec_flags_q <= spec_flags_d;
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Testbench for fp_addsub_seq: directed cases, handshake scenarios and random operands
// compared against an exact-integer reference model.
module tb_fp_addsub_seq;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, op = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic [W-1:0] a = '0, b = '0, result;
  logic [3:0]   flags;
  int           tests_run = 0, tests_failed = 0;

  fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  // Exact value arithmetic: each finite operand becomes sig * 2^(exp-1) in units of the
  // smallest normal ulp, the sum is exact, then rounded to nearest-even by remainder.
  function automatic void model(input logic [15:0] ia, input logic [15:0] ib, input logic iop,
                                output logic [15:0] r, output logic [3:0] f);
    logic   sa, sb, sgn, inx, na, nb, ia_inf, ib_inf;
    int     ea, eb, p, e, sh;
    longint ma, mb, va, vb, s, m, keep, rem, half;
    sa = ia[15]; ea = int'(ia[14:10]); ma = longint'(ia[9:0]);
    sb = ib[15] ^ iop; eb = int'(ib[14:10]); mb = longint'(ib[9:0]);
    na = (ea == 31) && (ma != 0); nb = (eb == 31) && (mb != 0);
    ia_inf = (ea == 31) && (ma == 0); ib_inf = (eb == 31) && (mb == 0);
    f = 4'b0000;
    r = 16'h0000;
    if (na || nb) r = 16'h7E00;
    else if (ia_inf && ib_inf) begin
      if (sa != sb) begin r = 16'h7E00; f = 4'b1000; end
      else r = {sa, 15'h7C00};
    end
    else if (ia_inf) r = {sa, 15'h7C00};
    else if (ib_inf) r = {sb, 15'h7C00};
    else if (ea == 0 && eb == 0) r = {sa & sb, 15'h0000};
    else if (ea == 0) r = {sb, ib[14:0]};
    else if (eb == 0) r = ia;
    else begin
      va = (longint'(1024) + ma) << (ea - 1);
      vb = (longint'(1024) + mb) << (eb - 1);
      if (sa) va = -va;
      if (sb) vb = -vb;
      s = va + vb;
      if (s == 0) r = 16'h0000;
      else begin
        sgn = (s < 0);
        m   = sgn ? -s : s;
        p   = 0;
        for (int i = 0; i < 62; i++) if (m[i]) p = i;
        e = p - MAN_W + 1;
        if (p > MAN_W) begin
          sh   = p - MAN_W;
          keep = m >> sh;
          rem  = m - (keep << sh);
          half = longint'(1) << (sh - 1);
          inx  = (rem != 0);
          if (rem > half || (rem == half && keep[0])) keep = keep + 1;
          if (keep == 2048) begin keep = 1024; e = e + 1; end
        end else begin
          keep = m << (MAN_W - p);
          inx  = 1'b0;
        end
        if (e >= 31) begin r = {sgn, 15'h7C00}; f = 4'b0101; end
        else if (e <= 0) begin r = {sgn, 15'h0000}; f = 4'b0011; end
        else begin r = {sgn, e[4:0], keep[9:0]}; f = {3'b000, inx}; end
      end
    end
  endfunction

  // Drives one operation from IDLE with out_ready high; lat = edges from accept to out_valid.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic iop,
                        output logic [15:0] r, output logic [3:0] f, output int lat);
    int n;
    a = ia; b = ib; op = iop; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    r = result; f = flags;
    if (!out_valid) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++; if (result !== 16'h0000) begin tests_failed++; $display("FAIL reset_result got %h want 0000", result); end
    tests_run++; if (flags !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags got %b want 0000", flags); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  logic [15:0] d_a  [0:13] = '{16'h3C00, 16'h4200, 16'h3C00, 16'h3C00, 16'h3C01, 16'h7BFF, 16'h7C00,
                                16'h7E00, 16'h8000, 16'h0401, 16'h0000, 16'hFC00, 16'h8000, 16'h3C00};
  logic [15:0] d_b  [0:13] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h1000, 16'h1000, 16'h7BFF, 16'hFC00,
                                16'h3C00, 16'h8000, 16'h0400, 16'hBC00, 16'h3C00, 16'h0000, 16'hBC00};
  logic        d_op [0:13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] d_r  [0:13] = '{16'h4000, 16'h4000, 16'h0000, 16'h3C00, 16'h3C02, 16'h7C00, 16'h7E00,
                                16'h7E00, 16'h8000, 16'h0000, 16'hBC00, 16'hFC00, 16'h8000, 16'h4000};
  logic [3:0]  d_f  [0:13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b1000,
                                4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

  task automatic test_directed();
    logic [15:0] r;
    logic [3:0]  f;
    int          lat;
    for (int i = 0; i < 14; i++) begin
      run_op(d_a[i], d_b[i], d_op[i], r, f, lat);
      tests_run++; if (r !== d_r[i]) begin tests_failed++; $display("FAIL directed_result[%0d] got %h want %h", i, r, d_r[i]); end
      tests_run++; if (f !== d_f[i]) begin tests_failed++; $display("FAIL directed_flags[%0d] got %b want %b", i, f, d_f[i]); end
      tests_run++; if (lat != 4) begin tests_failed++; $display("FAIL directed_latency[%0d] got %0d want 4", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [15:0] ia, ib, r, er;
    logic [3:0]  f, ef;
    logic        iop;
    int          lat;
    for (int i = 0; i < 300; i++) begin
      ia = 16'($urandom); ib = 16'($urandom); iop = 1'($urandom);
      case ($urandom_range(0, 3))
        0: ib[14:10] = ia[14:10];
        1: ib[14:10] = ia[14:10] - 5'($urandom_range(0, 13));
        2: begin ib[14:10] = ia[14:10]; ib[9:0] = ia[9:0] ^ 10'($urandom_range(0, 3)); end
        default: ;
      endcase
      model(ia, ib, iop, er, ef);
      run_op(ia, ib, iop, r, f, lat);
      tests_run++; if (r !== er || f !== ef || lat != 4)
        begin tests_failed++; $display("FAIL random %h %s %h got %h/%b lat %0d want %h/%b lat 4",
                                       ia, iop ? "-" : "+", ib, r, f, lat, er, ef); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] er, r;
    logic [3:0]  ef, f;
    int          n, lat;
    model(16'h4000, 16'h3C00, 1'b0, er, ef);
    a = 16'h4000; b = 16'h3C00; op = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    tests_run++; if (n != 4 || !out_valid) begin tests_failed++; $display("FAIL bp_latency got %0d want 4", n); end
    tests_run++; if (result !== er) begin tests_failed++; $display("FAIL bp_result got %h want %h", result, er); end
    for (int i = 0; i < 3; i++) begin
      a = 16'h3C00; b = 16'h3C00; in_valid = (i == 1);
      @(posedge clk); #1;
      tests_run++; if (out_valid !== 1'b1 || result !== er || flags !== ef || in_ready !== 1'b0)
        begin tests_failed++; $display("FAIL bp_hold[%0d] got v%b %h/%b rdy%b want v1 %h/%b rdy0",
                                       i, out_valid, result, flags, in_ready, er, ef); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin tests_failed++; $display("FAIL bp_release got v%b rdy%b want v0 rdy1", out_valid, in_ready); end
    run_op(16'h3C00, 16'h3800, 1'b1, r, f, lat);
    tests_run++; if (r !== 16'h3800 || f !== 4'b0000 || lat != 4)
      begin tests_failed++; $display("FAIL bp_next got %h/%b lat %0d want 3800/0000 lat 4", r, f, lat); end
  endtask

  task automatic test_back_to_back();
    int first, second, n;
    logic [15:0] er;
    logic [3:0]  ef;
    model(16'h4400, 16'h3C00, 1'b1, er, ef);
    a = 16'h4400; b = 16'h3C00; op = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    first = -1; second = -1; n = 0;
    while (second < 0 && n < 30) begin
      @(posedge clk); #1; n++;
      if (out_valid) begin
        tests_run++; if (result !== er || flags !== ef)
          begin tests_failed++; $display("FAIL b2b_result got %h/%b want %h/%b", result, flags, er, ef); end
        if (first < 0) first = n; else second = n;
      end
    end
    in_valid = 1'b0;
    tests_run++; if (first != 5) begin tests_failed++; $display("FAIL b2b_first got %0d want 5", first); end
    tests_run++; if (second - first != 6) begin tests_failed++; $display("FAIL b2b_spacing got %0d want 6", second - first); end
    @(posedge clk); #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_idle got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    logic [3:0]  f;
    int          lat, n;
    run_op(16'h3C00, 16'h3C00, 1'b0, r, f, lat);
    a = 16'h3C00; b = 16'h3C00; op = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    tests_run++; if (out_valid !== 1'b0 || result !== 16'h0000 || in_ready !== 1'b0)
      begin tests_failed++; $display("FAIL rst_norm got v%b %h rdy%b want v0 0000 rdy0", out_valid, result, in_ready); end
    @(posedge clk); #1; rst_n = 1'b1; #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_norm_release got %b want 1", in_ready); end
    @(posedge clk); #1;
    run_op(16'h3C00, 16'h4000, 1'b0, r, f, lat);
    tests_run++; if (r !== 16'h4200 || f !== 4'b0000 || lat != 4)
      begin tests_failed++; $display("FAIL rst_fresh got %h/%b lat %0d want 4200/0000 lat 4", r, f, lat); end
    a = 16'h4000; b = 16'h4000; op = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    tests_run++; if (out_valid !== 1'b1 || result !== 16'h4400)
      begin tests_failed++; $display("FAIL rst_done_pre got v%b %h want v1 4400", out_valid, result); end
    rst_n = 1'b0; #1;
    tests_run++; if (out_valid !== 1'b0 || result !== 16'h0000 || flags !== 4'b0000)
      begin tests_failed++; $display("FAIL rst_done got v%b %h/%b want v0 0000/0000", out_valid, result, flags); end
    @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog run did not complete in time");
    $fatal(1);
  end
endmodule
